median_window_ctrl: RTL
=======================

Name: median_window_ctrl

Overview:
- Streaming controller that sequences the combinational 3x3 approximate median filter datapath (cf).
- Accepts one 3-pixel image column per beat (top, mid, bottom rows of a strip) and maintains a 3-column sliding window.
- Drives cf's nine window inputs and its mode select, then registers cf's result into a valid/ready output stage.
- Sits between the line-buffer/column source and the pixel sink of the filter pipeline.

Parameters:
- DW, 8, pixel width; must match the cf datapath.
- IMG_W, 64, maximum columns per strip; minimum 3.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- cfg_mode  in  2  filter mode for cf.
- cfg_load  in  1  latch cfg_mode; honoured only in IDLE.
- in_valid  in  1  column beat valid.
- in_ready  out  1  column beat accepted when in_valid && in_ready.
- in_top, in_mid, in_bot  in  DW each  column pixels.
- in_last  in  1  final column of the strip.
- win_i0..win_i8  out  DW each  window pixels to cf inputs i0..i8.
- win_s  out  2  mode to cf input s.
- cf_y  in  DW  cf result, combinational from the win_* outputs.
- out_valid  out  1  result valid.
- out_ready  in  1  sink ready.
- out_data  out  DW  filtered pixel.
- out_last  out  1  last result of the strip.
- err_short  out  1  one-cycle pulse when a strip ends with fewer than 3 columns.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset: state=IDLE; every window register, mode_r, col_cnt, win_full, out_valid, out_data, out_last and err_short = 0.
- Window layout:
  - c0 = oldest column, c2 = newest.
  - win_i0/i1/i2 = top c0/c1/c2; win_i3/i4/i5 = mid c0/c1/c2; win_i6/i7/i8 = bot c0/c1/c2.
  - win_s = mode_r.
- Accept: on each accepted beat, c0<=c1, c1<=c2, c2<=input, and col_cnt increments. col_cnt width is clog2(IMG_W+1).
- States:
  - IDLE: cfg_load sets mode_r<=cfg_mode. The first accepted beat clears col_cnt to 1 and enters FILL.
  - FILL: entered with col_cnt 1. The beat that brings col_cnt to 3 enters RUN. An in_last beat while col_cnt<3 pulses err_short for one cycle, produces no output, and returns to IDLE; window contents are don't-care.
  - RUN: every accepted beat sets win_full. Terminal beat = in_last, or col_cnt reaching IMG_W (implicit last). The terminal beat marks the window last_pend and moves to IDLE once its result is captured.
- cfg_load outside IDLE is ignored; mode is constant for a whole strip.
- Result capture:
  - When win_full && (!out_valid || out_ready), on that edge: out_data<=cf_y, out_last<=last_pend, out_valid<=1, win_full<=0.
  - Otherwise out_valid clears when out_ready is high.
- Latency: the window-completing beat accepted at edge k gives out_valid high after edge k+1.
- in_ready = !win_full || !out_valid || out_ready (combinational). Sustains 1 beat/cycle with out_ready held high.
- Backpressure: out_data and out_last stay stable while out_valid && !out_ready. No beat is dropped or duplicated.
- Result count: a strip of N columns (3 <= N <= IMG_W) yields exactly N-2 outputs; only the last has out_last=1.
- Simultaneous events:
  - A new strip's first beat may be accepted in the same cycle the previous strip's last result is captured.
  - cfg_load together with an IDLE first beat: the mode is latched and applies to the new strip.
- Reset mid-strip: returns to IDLE on the next edge and discards pending results and out_valid.

Test Plan:
1. Stub cf_y=win_i4, mode 0, strip of 5 columns (mid pixels 10,20,30,40,50), in_last on column 5, out_ready=1 → outputs 20,30,40; out_last only on 40; busy low afterwards.
2. Ordering: columns (1,4,7),(2,5,8),(3,6,9) → win_i0..i8 = 1,2,3,4,5,6,7,8,9 on the cycle after the third beat.
3. Backpressure: out_ready=0 for 4 cycles mid-strip → in_ready drops once win_full && out_valid; out_data held; no loss across 6-column strip (4 outputs).
4. Short strip: 2 columns with in_last on column 2 → err_short pulses once; no out_valid; back to IDLE.
5. Mode: cfg_load=1 with mode 2 in IDLE → win_s=2. cfg_load with mode 1 during RUN → win_s stays 2.
6. IMG_W=4, no in_last, 6 beats → 2 outputs, second with out_last=1. Beats 5-6 start a new strip: FILL, no output. Assert rst mid-strip → out_valid=0, busy=0 next cycle.

Source files
------------

// File: rtl/median_window_ctrl.sv
// Streaming controller for the 3x3 approximate median datapath: builds a
// 3-column sliding window from column beats and registers the datapath result.
module median_window_ctrl #(
  parameter int DW    = 8,
  parameter int IMG_W = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    cfg_mode,
  input  logic          cfg_load,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_top,
  input  logic [DW-1:0] in_mid,
  input  logic [DW-1:0] in_bot,
  input  logic          in_last,
  output logic [DW-1:0] win_i0,
  output logic [DW-1:0] win_i1,
  output logic [DW-1:0] win_i2,
  output logic [DW-1:0] win_i3,
  output logic [DW-1:0] win_i4,
  output logic [DW-1:0] win_i5,
  output logic [DW-1:0] win_i6,
  output logic [DW-1:0] win_i7,
  output logic [DW-1:0] win_i8,
  output logic [1:0]    win_s,
  input  logic [DW-1:0] cf_y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          err_short,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  localparam int CW = $clog2(IMG_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [CW-1:0]        col_cnt_q, col_cnt_d;
  logic                 win_full_q, win_full_d;
  logic                 last_pend_q, last_pend_d;
  logic                 out_valid_q, out_valid_d;
  logic [DW-1:0]        out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;
  logic                 err_short_q, err_short_d;
  // Index 0 is the oldest column (c0), index 2 the newest (c2).
  logic [2:0][DW-1:0]   top_q, top_d;
  logic [2:0][DW-1:0]   mid_q, mid_d;
  logic [2:0][DW-1:0]   bot_q, bot_d;

  logic                 accept;
  logic                 capture;
  logic                 strip_start;
  logic [CW-1:0]        col_cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 2'd0;
      col_cnt_q   <= '0;
      win_full_q  <= 1'b0;
      last_pend_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err_short_q <= 1'b0;
      top_q       <= '0;
      mid_q       <= '0;
      bot_q       <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      col_cnt_q   <= col_cnt_d;
      win_full_q  <= win_full_d;
      last_pend_q <= last_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      err_short_q <= err_short_d;
      top_q       <= top_d;
      mid_q       <= mid_d;
      bot_q       <= bot_d;
    end
  end

  // Both ports transfer on a rising edge where valid && ready; the side that
  // raises valid holds its payload stable until that edge.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    col_cnt_d   = col_cnt_q;
    win_full_d  = win_full_q;
    last_pend_d = last_pend_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    err_short_d = 1'b0;
    top_d       = top_q;
    mid_d       = mid_q;
    bot_d       = bot_q;
    strip_start = 1'b0;

    in_ready    = !win_full_q || !out_valid_q || out_ready;
    accept      = in_valid && in_ready;
    capture     = win_full_q && (!out_valid_q || out_ready);
    col_cnt_inc = col_cnt_q + CW'(1);

    if (capture) begin
      out_data_d  = cf_y;
      out_last_d  = last_pend_q;
      out_valid_d = 1'b1;
      win_full_d  = 1'b0;
      last_pend_d = 1'b0;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      top_d = {in_top, top_q[2], top_q[1]};
      mid_d = {in_mid, mid_q[2], mid_q[1]};
      bot_d = {in_bot, bot_q[2], bot_q[1]};
    end

    case (state_q)
      S_IDLE: begin
        if (cfg_load) mode_d = cfg_mode;
        strip_start = accept;
      end
      S_FILL: begin
        if (accept) begin
          col_cnt_d = col_cnt_inc;
          if (col_cnt_inc == CW'(3)) begin
            state_d     = S_RUN;
            win_full_d  = 1'b1;
            last_pend_d = in_last || (col_cnt_inc == CW'(IMG_W));
          end else if (in_last) begin
            state_d     = S_IDLE;
            err_short_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        // With the terminal window pending, a beat can only be accepted on the
        // edge that captures it, so that beat opens the next strip.
        if (last_pend_q) begin
          if (capture) begin
            state_d     = S_IDLE;
            strip_start = accept;
          end
        end else if (accept) begin
          col_cnt_d   = col_cnt_inc;
          win_full_d  = 1'b1;
          last_pend_d = in_last || (col_cnt_inc == CW'(IMG_W));
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (strip_start) begin
      col_cnt_d = CW'(1);
      if (in_last) begin
        state_d     = S_IDLE;
        err_short_d = 1'b1;
      end else begin
        state_d = S_FILL;
      end
    end
  end

  assign win_i0    = top_q[0];
  assign win_i1    = top_q[1];
  assign win_i2    = top_q[2];
  assign win_i3    = mid_q[0];
  assign win_i4    = mid_q[1];
  assign win_i5    = mid_q[2];
  assign win_i6    = bot_q[0];
  assign win_i7    = bot_q[1];
  assign win_i8    = bot_q[2];
  assign win_s     = mode_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign err_short = err_short_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule
